// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the run controller and the single-cycle datapath.
interface pc_sequencer_if #(
  parameter int unsigned CNT_BITS = 16
);
  logic                go;
  logic                step_mode;
  logic                stall;
  logic                halt_req;
  logic [31:0]         next_pc;
  logic [31:0]         pc;
  logic                commit;
  logic                running;
  logic                halted;
  logic                fault;
  logic [2:0]          state;
  logic [CNT_BITS-1:0] instr_count;
  logic [CNT_BITS-1:0] stall_count;

  modport master (
    output go, step_mode, stall, halt_req, next_pc,
    input  pc, commit, running, halted, fault, state, instr_count, stall_count
  );

  modport slave (
    input  go, step_mode, stall, halt_req, next_pc,
    output pc, commit, running, halted, fault, state, instr_count, stall_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Run/step/pause/halt controller: owns the architectural PC, issues the commit
// strobe, and keeps saturating instruction/stall statistics.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_BITS = 16
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    PAUSE = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                go_d;
  logic                go_pulse;
  logic [31:0]         pc_q, pc_d;
  logic                fault_q, fault_d;
  logic [CNT_BITS-1:0] instr_q, stall_q;
  logic                inc_instr, inc_stall;
  logic                commit_c;

  assign go_pulse = bus.go & ~go_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      go_d    <= 1'b0;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      go_d    <= bus.go;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      // Counters stick at all-ones rather than wrapping.
      if (inc_instr && (instr_q != '1)) instr_q <= instr_q + CNT_BITS'(1);
      if (inc_stall && (stall_q != '1)) stall_q <= stall_q + CNT_BITS'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    commit_c  = 1'b0;
    inc_instr = 1'b0;
    inc_stall = 1'b0;
    case (state_q)
      IDLE, PAUSE: begin
        if (go_pulse) state_d = bus.step_mode ? STEP : RUN;
      end
      RUN, STEP: begin
        // Syscall commits but keeps its own address in pc.
        if (bus.halt_req && !bus.stall) begin
          commit_c  = 1'b1;
          inc_instr = 1'b1;
          state_d   = HALT;
        end else if (go_pulse && (state_q == RUN)) begin
          state_d = PAUSE;
        end else if (bus.stall) begin
          inc_stall = 1'b1;
        end else if (bus.next_pc[1:0] != 2'b00) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          commit_c  = 1'b1;
          inc_instr = 1'b1;
          pc_d      = bus.next_pc;
          state_d   = (state_q == STEP) ? PAUSE : RUN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign bus.commit      = commit_c & ~rst;
  assign bus.pc          = pc_q;
  assign bus.fault       = fault_q;
  assign bus.state       = state_q;
  assign bus.running     = (state_q == RUN) || (state_q == STEP);
  assign bus.halted      = (state_q == HALT);
  assign bus.instr_count = instr_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues the PC expected at each
// commit, a negedge monitor pops and compares whenever commit is seen.
module tb_pc_sequencer;
  localparam int unsigned CB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_BITS(CB)) bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_BITS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every commit must match the oldest queued PC.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.commit === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_commit: got pc %h expected no commit", bus.pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (bus.pc !== e) begin
            n_fail++;
            $display("FAIL commit_pc: got %h expected %h", bus.pc, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("pending_commits", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    bus.go = 1'b0; bus.step_mode = 1'b0; bus.stall = 1'b0;
    bus.halt_req = 1'b0; bus.next_pc = '0;
    #1;
    check("rst_async_pc", bus.pc, 32'h0);
    check("rst_async_state", 32'(bus.state), 32'd0);
    check("rst_async_fault", 32'(bus.fault), 32'd0);
    check("rst_async_icount", 32'(bus.instr_count), 32'd0);
    check("rst_async_commit", 32'(bus.commit), 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    mpc = 32'h0;
  endtask

  task automatic go_pulse(input logic sm);
    bus.step_mode = sm;
    bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
  endtask

  task automatic commits(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.next_pc = mpc + 32'd4;
      exp_q.push_back(mpc);
      cyc();
      mpc = mpc + 32'd4;
    end
  endtask

  initial begin
    bus.go = 1'b0; bus.step_mode = 1'b0; bus.stall = 1'b0;
    bus.halt_req = 1'b0; bus.next_pc = '0;
    mpc = '0;
    cyc();
    do_reset();

    // Reset state and free run
    repeat (5) cyc();
    check("idle_state", 32'(bus.state), 32'd0);
    check("idle_pc", bus.pc, 32'h0);
    check("idle_running", 32'(bus.running), 32'd0);
    check("idle_stallcnt", 32'(bus.stall_count), 32'd0);
    bus.next_pc = 32'd4;
    go_pulse(1'b0);
    commits(10);
    check("run_pc", bus.pc, 32'h28);
    check("run_icount", 32'(bus.instr_count), 32'd10);
    check("run_running", 32'(bus.running), 32'd1);
    do_reset();

    // Single step
    for (int unsigned k = 0; k < 3; k++) begin
      bus.next_pc = mpc + 32'd4;
      go_pulse(1'b1);
      check("step_state", 32'(bus.state), 32'd2);
      commits(1);
      check("step_pause", 32'(bus.state), 32'd3);
      bus.step_mode = 1'b0;
      cyc();
      check("step_pause_hold", 32'(bus.state), 32'd3);
      cyc();
    end
    check("step_pc", bus.pc, 32'hC);
    check("step_icount", 32'(bus.instr_count), 32'd3);
    do_reset();

    // Stall with halt_req, then halt
    go_pulse(1'b0);
    commits(2);
    bus.next_pc = mpc + 32'd4;
    bus.stall = 1'b1;
    cyc();
    bus.halt_req = 1'b1;
    cyc();
    bus.halt_req = 1'b0;
    cyc();
    check("stall_pc_held", bus.pc, 32'h8);
    bus.stall = 1'b0;
    bus.halt_req = 1'b1;
    exp_q.push_back(mpc);
    cyc();
    bus.halt_req = 1'b0;
    check("halt_stallcnt", 32'(bus.stall_count), 32'd3);
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_state", 32'(bus.state), 32'd4);
    check("halt_pc", bus.pc, 32'h8);
    check("halt_icount", 32'(bus.instr_count), 32'd3);
    go_pulse(1'b0); cyc();
    go_pulse(1'b1); cyc();
    check("halt_sticky_state", 32'(bus.state), 32'd4);
    check("halt_sticky_pc", bus.pc, 32'h8);
    do_reset();

    // Misaligned next_pc
    go_pulse(1'b0);
    bus.next_pc = 32'h40;
    exp_q.push_back(mpc);
    cyc();
    mpc = 32'h40;
    bus.next_pc = 32'h46;
    cyc();
    check("fault_flag", 32'(bus.fault), 32'd1);
    check("fault_state", 32'(bus.state), 32'd4);
    check("fault_pc", bus.pc, 32'h40);
    check("fault_icount", 32'(bus.instr_count), 32'd1);
    cyc();
    check("fault_pc_frozen", bus.pc, 32'h40);
    do_reset();

    // Held go pauses once; re-press resumes
    go_pulse(1'b0);
    commits(2);
    bus.go = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      cyc();
      check("hold_pause", 32'(bus.state), 32'd3);
    end
    bus.go = 1'b0;
    cyc();
    check("pause_pc", bus.pc, 32'h8);
    go_pulse(1'b0);
    check("resume_state", 32'(bus.state), 32'd1);
    commits(2);
    check("resume_pc", bus.pc, 32'h10);
    check("resume_icount", 32'(bus.instr_count), 32'd4);
    do_reset();

    // Wrap, saturation, asynchronous reset mid-run
    go_pulse(1'b0);
    bus.next_pc = 32'hFFFF_FFFC;
    exp_q.push_back(mpc);
    cyc();
    mpc = 32'hFFFF_FFFC;
    check("wrap_hi_pc", bus.pc, 32'hFFFF_FFFC);
    commits(1);
    check("wrap_pc", bus.pc, 32'h0);
    commits(13);
    check("sat_15", 32'(bus.instr_count), 32'd15);
    commits(3);
    check("sat_hold", 32'(bus.instr_count), 32'd15);
    check("sat_pc", bus.pc, mpc);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Run/step/pause/halt controller for the single-cycle datapath.
- Owns the architectural PC register and loads it from the next-PC logic's NextPC only on committed cycles.
- Provides a commit strobe. Downstream branch-statistics counters use it as their count enable, so they count only committed instructions.
- Detects halt (syscall with $v0 == 10), misaligned fetch, and stalls. Keeps instruction and stall statistics.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_BITS, 16, width of instr_count and stall_count (saturating)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
go  input  1  start/resume/pause request, level; rising edge internally detected
step_mode  input  1  sampled at go edge: 1 = single-step, 0 = free run
stall  input  1  datapath not ready; current instruction must not commit
halt_req  input  1  current instruction is syscall with RegRS == 32'ha
next_pc  input  32  NextPC from next-PC logic for current instruction
pc  output  32  architectural PC (registered)
commit  output  1  combinational; PC and statistics advance at next edge
running  output  1  registered; state is RUN or STEP
halted  output  1  registered; state is HALT
fault  output  1  registered; sticky, set on misaligned next_pc
state  output  3  IDLE=0, RUN=1, STEP=2, PAUSE=3, HALT=4
instr_count  output  CNT_BITS  committed instructions, saturating
stall_count  output  CNT_BITS  stalled cycles in RUN/STEP, saturating

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, go_d=0, counts=0, fault=0, running=0, halted=0.
- commit=0 whenever rst is high.
- go_pulse = go & ~go_d. go_d is a register clocked every cycle.
- IDLE / PAUSE: commit=0, pc held. On go_pulse, go to STEP if step_mode=1, otherwise RUN.
- RUN / STEP: evaluate in priority order each cycle:
  1. halt_req & ~stall: commit=1 and instr_count+1. pc is NOT updated; it holds the syscall address. Next state HALT.
  2. go_pulse (RUN only): commit=0, next state PAUSE. In STEP, go_pulse is ignored.
  3. stall: commit=0, stall_count+1, pc held, state unchanged.
  4. next_pc[1:0] != 0: commit=0, fault<=1, next state HALT. pc keeps the faulting instruction's address.
  5. Otherwise: commit=1, pc<=next_pc, instr_count+1. RUN stays RUN; STEP goes to PAUSE.
- HALT: terminal until rst. commit=0, go ignored, pc and counters frozen.
- Outputs running and halted follow the registered state with no extra latency: both reflect the state register in the same cycle as state.
- Counters saturate at all-ones; no wrap.
- Simultaneous halt_req and stall: the stall wins; halt is taken on the first unstalled cycle.
- rst asserted mid-run: everything returns to reset values at once, including sticky fault.
- next_pc is loaded verbatim, including wrap from 32'hFFFF_FFFC to 0 (alignment check still applies).
- step_mode changes outside a go edge have no effect.

Test Plan:
- Reset, hold go=0 for 5 cycles -> state=0, pc=0, commit=0, counts=0. Pulse go with step_mode=0 and next_pc=pc+4 -> after 10 cycles pc=32'h28, instr_count=10, running=1.
- step_mode=1, three go pulses spaced 4 cycles apart -> exactly 3 commits; pc=32'hC; state=PAUSE between pulses; commit high for exactly one cycle per pulse.
- In RUN, stall=1 for 3 cycles with halt_req=1 during the 2nd stalled cycle -> no commit while stalled; stall_count=3. First unstalled cycle with halt_req=1 -> commit=1, pc unchanged, next state HALT (halted=1). Later go pulses ignored.
- In RUN at pc=32'h40, next_pc=32'h0000_0046 -> fault=1, state=HALT, pc stays 32'h40, instr_count unchanged.
- In RUN, go pulse while go is held high for 4 cycles -> single transition to PAUSE with no commit that cycle. Release then re-press go -> back to RUN. Commits resume from the same pc.
- Force instr_count to all-ones via 2^CNT_BITS commits (reduce CNT_BITS to 4) -> holds at 4'hF. Assert rst mid-RUN -> pc=RESET_PC, fault=0, counts=0 asynchronously, before the next clock edge.
